// File: rtl/param_vote_logger_if.sv
// Bus between the ballot front panel and the vote logger core.
// The VOTE_LEADER_EN macro adds the leader_idx / leader_tie outputs.
interface param_vote_logger_if #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int REJ_W    = 8
);
    localparam int IDX_W = $clog2(NUM_CAND);
    localparam int TOT_W = CNT_W + IDX_W;

    logic                      mode;
    logic                      ballot_en;
    logic [NUM_CAND-1:0]       cand_vote_valid;
    logic [NUM_CAND*CNT_W-1:0] cand_vote_recvd;
    logic [TOT_W-1:0]          total_votes;
    logic [REJ_W-1:0]          rejected;
    logic                      armed;
    logic                      vote_ack;
    logic                      vote_rej;
`ifdef VOTE_LEADER_EN
    logic [IDX_W-1:0]          leader_idx;
    logic                      leader_tie;

    modport master (
        output mode, ballot_en, cand_vote_valid,
        input  cand_vote_recvd, total_votes, rejected, armed, vote_ack, vote_rej,
               leader_idx, leader_tie
    );
    modport slave (
        input  mode, ballot_en, cand_vote_valid,
        output cand_vote_recvd, total_votes, rejected, armed, vote_ack, vote_rej,
               leader_idx, leader_tie
    );
`else
    modport master (
        output mode, ballot_en, cand_vote_valid,
        input  cand_vote_recvd, total_votes, rejected, armed, vote_ack, vote_rej
    );
    modport slave (
        input  mode, ballot_en, cand_vote_valid,
        output cand_vote_recvd, total_votes, rejected, armed, vote_ack, vote_rej
    );
`endif
endinterface

// File: rtl/param_vote_logger.sv
// N-candidate vote logger: one vote per armed ballot, multi-press rejection, saturating tallies.
// Optional leader tracking is enabled with the VOTE_LEADER_EN macro.
module param_vote_logger #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int REJ_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    param_vote_logger_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_CAND);
    localparam int TOT_W = CNT_W + IDX_W;

    typedef enum logic [1:0] {IDLE, ARMED, WAIT_REL} state_t;

    state_t                          state, state_nxt;
    logic [NUM_CAND-1:0]             btn_q;
    logic [NUM_CAND-1:0]             rise;
    logic                            accept, reject;
    logic [NUM_CAND-1:0][CNT_W-1:0]  tally;
    logic [TOT_W-1:0]                total;
    logic [REJ_W-1:0]                rej_cnt;
    logic                            ack_r, rej_r;

    assign rise = bus.cand_vote_valid & ~btn_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            btn_q <= '0;
        end else begin
            state <= state_nxt;
            btn_q <= bus.cand_vote_valid;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (bus.ballot_en && !bus.mode) state_nxt = ARMED;
            ARMED: begin
                if (bus.mode)              state_nxt = IDLE;
                else if ($onehot(rise))    state_nxt = WAIT_REL;
            end
            WAIT_REL: if (bus.cand_vote_valid == '0) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // A mode change while armed cancels the ballot, so it masks both strobes.
    always_comb begin
        accept = 1'b0;
        reject = 1'b0;
        if (state == ARMED && !bus.mode) begin
            accept = $onehot(rise);
            reject = (rise != '0) && !$onehot(rise);
        end
    end

    for (genvar i = 0; i < NUM_CAND; i++) begin : g_lane
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                tally[i] <= '0;
            else if (accept && rise[i] && tally[i] != '1)
                tally[i] <= tally[i] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total   <= '0;
            rej_cnt <= '0;
            ack_r   <= 1'b0;
            rej_r   <= 1'b0;
        end else begin
            if (accept && total != '1)   total   <= total + 1'b1;
            if (reject && rej_cnt != '1) rej_cnt <= rej_cnt + 1'b1;
            ack_r <= accept;
            rej_r <= reject;
        end
    end

    assign bus.cand_vote_recvd = tally;
    assign bus.total_votes     = total;
    assign bus.rejected        = rej_cnt;
    assign bus.armed           = (state == ARMED);
    assign bus.vote_ack        = ack_r;
    assign bus.vote_rej        = rej_r;

`ifdef VOTE_LEADER_EN
    logic [IDX_W-1:0] best_idx, leader_idx_r;
    logic [CNT_W-1:0] best_val;
    logic             best_tie, leader_tie_r;

    // Strict '>' keeps the lowest index on ties; tie clears whenever a new max appears.
    always_comb begin
        best_idx = '0;
        best_val = tally[0];
        best_tie = 1'b0;
        for (int i = 1; i < NUM_CAND; i++) begin
            if (tally[i] > best_val) begin
                best_idx = IDX_W'(i);
                best_val = tally[i];
                best_tie = 1'b0;
            end else if (tally[i] == best_val) begin
                best_tie = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leader_idx_r <= '0;
            leader_tie_r <= 1'b1;
        end else begin
            leader_idx_r <= best_idx;
            leader_tie_r <= best_tie;
        end
    end

    assign bus.leader_idx = leader_idx_r;
    assign bus.leader_tie = leader_tie_r;
`endif
endmodule

// File: tb/tb_param_vote_logger.sv
// Directed bench for param_vote_logger (NUM_CAND=4, CNT_W=8, REJ_W=8).
module tb_param_vote_logger;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   ack_cnt = 0;
    int   rej_cnt = 0;

    always #5 clk = ~clk;

    param_vote_logger_if #(.NUM_CAND(4), .CNT_W(8), .REJ_W(8)) bus();

    param_vote_logger #(.NUM_CAND(4), .CNT_W(8), .REJ_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [3:0][7:0] tl;
    assign tl = bus.cand_vote_recvd;

    always @(negedge clk) begin
        if (bus.vote_ack) ack_cnt++;
        if (bus.vote_rej) rej_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.mode = 1'b0;
        bus.ballot_en = 1'b0;
        bus.cand_vote_valid = 4'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Arm, press the given mask for one cycle, release, return to IDLE.
    task automatic cast(input logic [3:0] mask);
        bus.ballot_en = 1'b1;
        tick();
        bus.ballot_en = 1'b0;
        bus.cand_vote_valid = mask;
        tick();
        bus.cand_vote_valid = 4'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (tl !== 32'h0) begin bad++; $display("FAIL rst_tally got=%h want=0", tl); end
        total++; if (bus.total_votes !== 10'd0 || bus.rejected !== 8'd0) begin bad++; $display("FAIL rst_counts got=%0d/%0d want=0/0", bus.total_votes, bus.rejected); end
        total++; if (bus.armed !== 1'b0 || bus.vote_ack !== 1'b0 || bus.vote_rej !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b%b want=000", bus.armed, bus.vote_ack, bus.vote_rej); end
        repeat (3) cast(4'b0001);
        cast(4'b0010);
        repeat (2) cast(4'b1000);
        total++; if (tl !== {8'd2, 8'd0, 8'd1, 8'd3}) begin bad++; $display("FAIL pre_rst_tally got=%h want=02000103", tl); end
        total++; if (bus.total_votes !== 10'd6) begin bad++; $display("FAIL pre_rst_total got=%0d want=6", bus.total_votes); end
        // assert reset mid-ballot, between clock edges
        bus.ballot_en = 1'b1;
        tick();
        bus.ballot_en = 1'b0;
        bus.cand_vote_valid = 4'b0100;
        #2 reset = 1'b0;
        #1;
        total++; if (tl !== 32'h0 || bus.total_votes !== 10'd0) begin bad++; $display("FAIL async_rst got=%h/%0d want=0/0", tl, bus.total_votes); end
        total++; if (bus.armed !== 1'b0) begin bad++; $display("FAIL async_rst_armed got=%b want=0", bus.armed); end
        bus.cand_vote_valid = 4'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();
        total++; if (bus.armed !== 1'b0 || tl !== 32'h0) begin bad++; $display("FAIL post_rst got=%b/%h want=0/0", bus.armed, tl); end
    endtask

    task automatic test_single();
        int a0;
        do_reset();
        a0 = ack_cnt;
        bus.ballot_en = 1'b1;
        tick();
        bus.ballot_en = 1'b0;
        total++; if (bus.armed !== 1'b1) begin bad++; $display("FAIL single_armed got=%b want=1", bus.armed); end
        bus.cand_vote_valid = 4'b0100;
        tick();
        total++; if (bus.vote_ack !== 1'b1 || tl[2] !== 8'd1 || bus.total_votes !== 10'd1) begin bad++; $display("FAIL single_vote got=%b/%0d/%0d want=1/1/1", bus.vote_ack, tl[2], bus.total_votes); end
        repeat (4) tick();
        bus.cand_vote_valid = 4'b0;
        tick();
        tick();
        // presses without re-arming
        bus.cand_vote_valid = 4'b0100;
        tick();
        tick();
        bus.cand_vote_valid = 4'b0;
        tick();
        bus.cand_vote_valid = 4'b0100;
        tick();
        bus.cand_vote_valid = 4'b0;
        tick();
        total++; if (tl !== {8'd0, 8'd1, 8'd0, 8'd0} || bus.total_votes !== 10'd1) begin bad++; $display("FAIL single_hold got=%h/%0d want=00010000/1", tl, bus.total_votes); end
        total++; if (ack_cnt - a0 !== 1) begin bad++; $display("FAIL single_ack_cnt got=%0d want=1", ack_cnt - a0); end
    endtask

    task automatic test_multi();
        int r0;
        do_reset();
        r0 = rej_cnt;
        bus.ballot_en = 1'b1;
        tick();
        bus.ballot_en = 1'b0;
        bus.cand_vote_valid = 4'b1001;
        tick();
        total++; if (bus.vote_rej !== 1'b1 || bus.vote_ack !== 1'b0 || bus.rejected !== 8'd1) begin bad++; $display("FAIL multi_rej got=%b/%b/%0d want=1/0/1", bus.vote_rej, bus.vote_ack, bus.rejected); end
        total++; if (tl !== 32'h0 || bus.armed !== 1'b1) begin bad++; $display("FAIL multi_state got=%h/%b want=0/1", tl, bus.armed); end
        bus.cand_vote_valid = 4'b0;
        tick();
        total++; if (bus.vote_rej !== 1'b0) begin bad++; $display("FAIL multi_pulse got=%b want=0", bus.vote_rej); end
        bus.cand_vote_valid = 4'b1000;
        tick();
        total++; if (tl[3] !== 8'd1 || bus.vote_ack !== 1'b1 || bus.total_votes !== 10'd1 || bus.rejected !== 8'd1) begin bad++; $display("FAIL multi_then_one got=%0d/%b/%0d/%0d want=1/1/1/1", tl[3], bus.vote_ack, bus.total_votes, bus.rejected); end
        total++; if (rej_cnt - r0 !== 1) begin bad++; $display("FAIL multi_rej_cnt got=%0d want=1", rej_cnt - r0); end
        bus.cand_vote_valid = 4'b0;
        tick();
        tick();
    endtask

    task automatic test_held();
        do_reset();
        bus.cand_vote_valid = 4'b0010;
        tick();
        bus.ballot_en = 1'b1;
        tick();
        bus.ballot_en = 1'b0;
        tick();
        tick();
        total++; if (tl[1] !== 8'd0 || bus.armed !== 1'b1) begin bad++; $display("FAIL held_ignored got=%0d/%b want=0/1", tl[1], bus.armed); end
        bus.cand_vote_valid = 4'b0;
        tick();
        bus.cand_vote_valid = 4'b0010;
        tick();
        total++; if (tl[1] !== 8'd1 || bus.vote_ack !== 1'b1) begin bad++; $display("FAIL held_repress got=%0d/%b want=1/1", tl[1], bus.vote_ack); end
        bus.cand_vote_valid = 4'b0;
        tick();
        tick();
    endtask

    task automatic test_saturate();
        do_reset();
        repeat (255) cast(4'b0001);
        total++; if (tl[0] !== 8'd255 || bus.total_votes !== 10'd255) begin bad++; $display("FAIL sat_fill got=%0d/%0d want=255/255", tl[0], bus.total_votes); end
        bus.ballot_en = 1'b1;
        tick();
        bus.ballot_en = 1'b0;
        bus.cand_vote_valid = 4'b0001;
        tick();
        total++; if (tl[0] !== 8'd255 || bus.vote_ack !== 1'b1 || bus.total_votes !== 10'd256) begin bad++; $display("FAIL sat_hold got=%0d/%b/%0d want=255/1/256", tl[0], bus.vote_ack, bus.total_votes); end
        total++; if (tl[3:1] !== 24'h0) begin bad++; $display("FAIL sat_others got=%h want=0", tl[3:1]); end
        bus.cand_vote_valid = 4'b0;
        tick();
        tick();
    endtask

    task automatic test_cancel();
        int a0;
        do_reset();
        a0 = ack_cnt;
        bus.ballot_en = 1'b1;
        tick();
        bus.ballot_en = 1'b0;
        bus.mode = 1'b1;
        tick();
        total++; if (bus.armed !== 1'b0) begin bad++; $display("FAIL cancel_armed got=%b want=0", bus.armed); end
        bus.cand_vote_valid = 4'b0100;
        tick();
        bus.cand_vote_valid = 4'b0;
        bus.ballot_en = 1'b1;
        tick();
        tick();
        total++; if (bus.armed !== 1'b0 || tl !== 32'h0 || ack_cnt != a0) begin bad++; $display("FAIL cancel_nocount got=%b/%h/%0d want=0/0/0", bus.armed, tl, ack_cnt - a0); end
        bus.ballot_en = 1'b0;
        bus.mode = 1'b0;
        tick();
    endtask

`ifdef VOTE_LEADER_EN
    task automatic test_leader();
        do_reset();
        total++; if (bus.leader_idx !== 2'd0 || bus.leader_tie !== 1'b1) begin bad++; $display("FAIL leader_rst got=%0d/%b want=0/1", bus.leader_idx, bus.leader_tie); end
        repeat (4) cast(4'b0001);
        repeat (4) cast(4'b0010);
        cast(4'b0100);
        total++; if (bus.leader_idx !== 2'd0 || bus.leader_tie !== 1'b1) begin bad++; $display("FAIL leader_tie got=%0d/%b want=0/1", bus.leader_idx, bus.leader_tie); end
        cast(4'b0010);
        total++; if (bus.leader_idx !== 2'd1 || bus.leader_tie !== 1'b0) begin bad++; $display("FAIL leader_one got=%0d/%b want=1/0", bus.leader_idx, bus.leader_tie); end
    endtask
`endif

    initial begin
        bus.mode = 1'b0;
        bus.ballot_en = 1'b0;
        bus.cand_vote_valid = 4'b0;
        test_reset();
        test_single();
        test_multi();
        test_held();
        test_saturate();
        test_cancel();
`ifdef VOTE_LEADER_EN
        test_leader();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
